shiftreg_credit_rx: RTL

//  Receive end of the gated shift-register delay line: valid-only, Depth-cycle latency, no backpressure.

---
 rtl/shiftreg_credit_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shiftreg_credit_rx.sv
// Receive end of a credit-gated shift-register delay line.
// Buffers arriving beats in a FIFO and owns the credits that gate launches.
//
// Ports:
//   clk_i, rst_i    clock (rising edge) and synchronous active-high reset
//   launch_i        sender launches one beat into the delay line this cycle
//   launch_ready_o  at least one credit is available
//   valid_i/data_i  beat arriving from the delay-line output (no backpressure)
//   valid_o/data_o  FIFO head, popped when valid_o && ready_i
//   ready_i         downstream accepts the head
//   credits_o       current credit count
//   err_overflow_o  sticky: beat arrived into a full FIFO with no pop
//   err_launch_o    sticky: launch attempted with no credit
module shiftreg_credit_rx #(
    parameter int Depth      = 4,
    parameter int DataWidth  = 32,
    parameter int NumCredits = 5
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             launch_i,
    output logic                             launch_ready_o,
    input  logic                             valid_i,
    input  logic [DataWidth-1:0]             data_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [DataWidth-1:0]             data_o,
    output logic [$clog2(NumCredits+1)-1:0]  credits_o,
    output logic                             err_overflow_o,
    output logic                             err_launch_o
);

    localparam int CW = $clog2(NumCredits + 1);
    localparam int PW = (NumCredits > 1) ? $clog2(NumCredits) : 1;
    localparam logic [CW-1:0] MaxCred = CW'(NumCredits);
    localparam logic [PW-1:0] LastPtr = PW'(NumCredits - 1);

    if (NumCredits < 1 || Depth < 1) begin : g_bad_cfg
        $error("shiftreg_credit_rx: NumCredits and Depth must be >= 1");
    end

    logic [DataWidth-1:0] r_mem [NumCredits];
    logic [PW-1:0]        r_wr;
    logic [PW-1:0]        r_rd;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        r_credit;
    logic                 r_err_ovf;
    logic                 r_err_launch;

    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_launch_ok;
    logic                 w_launch_bad;
    logic                 w_credit_ret;
    logic [PW-1:0]        w_wr_nxt;
    logic [PW-1:0]        w_rd_nxt;

    assign w_full       = (r_count == MaxCred);
    assign valid_o      = (r_count != '0);
    assign w_pop        = valid_o && ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push       = valid_i && (!w_full || w_pop);
    assign w_drop       = valid_i && w_full && !w_pop;
    assign w_launch_ok  = launch_i && (r_credit != '0);
    assign w_launch_bad = launch_i && (r_credit == '0);
    // Returned credits saturate so illegal traffic cannot wrap the counter.
    assign w_credit_ret = w_pop && (r_credit != MaxCred);

    // Pointers wrap explicitly so non-power-of-2 depths work.
    assign w_wr_nxt = (r_wr == LastPtr) ? '0 : r_wr + PW'(1);
    assign w_rd_nxt = (r_rd == LastPtr) ? '0 : r_rd + PW'(1);

    assign data_o         = r_mem[r_rd];
    assign launch_ready_o = (r_credit != '0);
    assign credits_o      = r_credit;
    assign err_overflow_o = r_err_ovf;
    assign err_launch_o   = r_err_launch;

    // Storage is not reset; valid_o masks stale entries.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            r_mem[r_wr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd <= w_rd_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_credit <= MaxCred;
        end else if (w_launch_ok && !w_pop) begin
            r_credit <= r_credit - CW'(1);
        end else if (w_credit_ret && !w_launch_ok) begin
            r_credit <= r_credit + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_ovf    <= 1'b0;
            r_err_launch <= 1'b0;
        end else begin
            if (w_drop) begin
                r_err_ovf <= 1'b1;
            end
            if (w_launch_bad) begin
                r_err_launch <= 1'b1;
            end
        end
    end

endmodule
